// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: controller commands, instruction-memory read port and
// the fetch results returned to the controller.
// master: the fetch unit itself. slave: controller plus instruction memory.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              PC_clr;
  logic              PC_up;
  logic              IR_ld;
  logic [15:0]       IM_data;
  logic              IM_ack;
  logic              IM_req;
  logic [ADDR_W-1:0] IM_addr;
  logic [15:0]       IR;
  logic [ADDR_W-1:0] PC;
  logic              Fetch_rdy;
  logic              Fetch_err;

  modport master (
    input  PC_clr, PC_up, IR_ld, IM_data, IM_ack,
    output IM_req, IM_addr, IR, PC, Fetch_rdy, Fetch_err
  );

  modport slave (
    output PC_clr, PC_up, IR_ld, IM_data, IM_ack,
    input  IM_req, IM_addr, IR, PC, Fetch_rdy, Fetch_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-entry prefetching instruction fetch unit.
// States: StReq (request outstanding), StFull (buffer holds instruction at PC),
// StDrop (waiting out a request made stale by a PC change).
// Optional macro FETCH_BYPASS_EN: an IR_ld that coincides with the acknowledge of
// a still-valid request loads IM_data straight into IR instead of flagging an error.
module instr_fetch_unit #(
  parameter int unsigned          ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input logic                 Clk,
  input logic                 Reset,
  instr_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {StReq, StFull, StDrop} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       ir_q, ir_d;
  logic [15:0]       buf_q, buf_d;
  logic              err_q, err_d;
  logic              started_q;
  logic              pc_chg;

  assign pc_chg = bus.PC_clr | bus.PC_up;

  // Next-state logic: PC update, fetch FSM, IR load and sticky error flag.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    buf_d   = buf_q;
    err_d   = err_q;

    if (bus.PC_clr) begin
      pc_d = RESET_PC;
    end else if (bus.PC_up) begin
      pc_d = pc_q + ADDR_W'(1);
    end

    case (state_q)
      StReq: begin
        if (bus.IM_ack) begin
          if (pc_chg) begin
            // Request completes on the old address; reissue at the new PC directly.
            addr_d = pc_d;
          end else begin
            buf_d   = bus.IM_data;
            state_d = StFull;
          end
        end else if (pc_chg) begin
          state_d = StDrop;
        end
        if (bus.IR_ld) begin
`ifdef FETCH_BYPASS_EN
          if (bus.IM_ack && !pc_chg) begin
            ir_d = bus.IM_data;
          end else begin
            err_d = 1'b1;
          end
`else
          err_d = 1'b1;
`endif
        end
      end
      StDrop: begin
        if (bus.IM_ack) begin
          state_d = StReq;
          addr_d  = pc_d;
        end
        if (bus.IR_ld) begin
          err_d = 1'b1;
        end
      end
      StFull: begin
        // IR takes the buffer before any PC change invalidates it.
        if (bus.IR_ld) begin
          ir_d = buf_q;
        end
        if (pc_chg) begin
          state_d = StReq;
          addr_d  = pc_d;
        end
      end
      default: begin
        state_d = StReq;
        addr_d  = pc_d;
      end
    endcase

    if (bus.PC_clr) begin
      err_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StReq;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      ir_q      <= '0;
      buf_q     <= '0;
      err_q     <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      ir_q      <= ir_d;
      buf_q     <= buf_d;
      err_q     <= err_d;
      started_q <= 1'b1;
    end
  end

  // Outputs; the request is held off until the first edge after reset release.
  always_comb begin
    bus.IM_req    = started_q && (state_q != StFull);
    bus.IM_addr   = addr_q;
    bus.IR        = ir_q;
    bus.PC        = pc_q;
    bus.Fetch_rdy = (state_q == StFull);
    bus.Fetch_err = err_q;
  end

endmodule
